// File: rtl/window_control.sv
// window_control: register-window pointer (CWP) and invalid mask (WIM) control.
// Parameters: NWIN windows (power of two), CWPW = log2(NWIN).
// Inputs : Clk, Rst_n (async, active-low), Save, Restore, TrapEntry, Rett,
//          WrCWP/CWPIn, WrWIM/WIMIn.
// Outputs: CWP, WIM, BlkLocal/BlkOut (one-hot block enables),
//          Overflow/Underflow (one-cycle trap pulses), WrPending.
// Macro WIN_DELAYED_WRITE_EN: CWP/WIM writes pass through a 3-stage pipeline.
module window_control #(
    parameter int NWIN = 8,
    parameter int CWPW = 3
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Save,
    input  logic            Restore,
    input  logic            TrapEntry,
    input  logic            Rett,
    input  logic            WrCWP,
    input  logic [CWPW-1:0] CWPIn,
    input  logic            WrWIM,
    input  logic [NWIN-1:0] WIMIn,
    output logic [CWPW-1:0] CWP,
    output logic [NWIN-1:0] WIM,
    output logic [NWIN-1:0] BlkLocal,
    output logic [NWIN-1:0] BlkOut,
    output logic            Overflow,
    output logic            Underflow,
    output logic            WrPending
);
    logic            wr_cwp_c, wr_wim_c, commit;
    logic [CWPW-1:0] cwp_c, cwp_m1, cwp_p1, cwp_n;
    logic [NWIN-1:0] wim_c;
    logic            ev_dec, ev_inc, ovf_n, unf_n;

`ifdef WIN_DELAYED_WRITE_EN
    logic [2:0]           pc_v, pw_v;
    logic [2:0][CWPW-1:0] pc_d;
    logic [2:0][NWIN-1:0] pw_d;

    // A fresh write to a register cancels any older one still in flight.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc_v <= '0;
            pw_v <= '0;
            pc_d <= '0;
            pw_d <= '0;
        end else begin
            pc_v <= {pc_v[1:0] & {2{~WrCWP}}, WrCWP};
            pw_v <= {pw_v[1:0] & {2{~WrWIM}}, WrWIM};
            pc_d <= {pc_d[1:0], CWPIn};
            pw_d <= {pw_d[1:0], WIMIn};
        end
    end

    assign wr_cwp_c  = pc_v[2];
    assign cwp_c     = pc_d[2];
    assign wr_wim_c  = pw_v[2];
    assign wim_c     = pw_d[2];
    assign WrPending = |{pc_v, pw_v};
`else
    assign wr_cwp_c  = WrCWP;
    assign cwp_c     = CWPIn;
    assign wr_wim_c  = WrWIM;
    assign wim_c     = WIMIn;
    assign WrPending = 1'b0;
`endif

    // CWPW-bit arithmetic wraps modulo NWIN since NWIN is a power of two.
    assign cwp_m1 = CWP - 1'b1;
    assign cwp_p1 = CWP + 1'b1;
    assign commit = wr_cwp_c | wr_wim_c;

    // Rett outranks Save, Save outranks Restore; Save+Restore alone is a no-op.
    assign ev_dec = !commit && !TrapEntry && !Rett && Save && !Restore;
    assign ev_inc = !commit && !TrapEntry && (Rett || (Restore && !Save));
    assign ovf_n  = ev_dec && WIM[cwp_m1];
    assign unf_n  = ev_inc && WIM[cwp_p1];

    always_comb begin
        cwp_n = wr_cwp_c               ? cwp_c  :
                commit                 ? CWP    :
                TrapEntry              ? cwp_m1 :
                (ev_inc && !WIM[cwp_p1]) ? cwp_p1 :
                (ev_dec && !WIM[cwp_m1]) ? cwp_m1 : CWP;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            CWP       <= '0;
            WIM       <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            CWP       <= cwp_n;
            WIM       <= wr_wim_c ? wim_c : WIM;
            Overflow  <= ovf_n;
            Underflow <= unf_n;
        end
    end

    assign BlkLocal = NWIN'(1) << CWP;
    assign BlkOut   = NWIN'(1) << cwp_m1;
endmodule

// File: doc/window_control.md
WINDOW_CONTROL -- requirements
Module: window_control

Interface
REQ-001 SHALL have parameter NWIN, default 8, number of register windows (power of two, 4..32).
REQ-002 SHALL have parameter CWPW, default 3, CWP width, equal to log2(NWIN).
REQ-003 SHALL have port Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-005 SHALL have port Save, input, 1 bit, SAVE request: CWP-1.
REQ-006 SHALL have port Restore, input, 1 bit, RESTORE request: CWP+1.
REQ-007 SHALL have port TrapEntry, input, 1 bit, trap entry: CWP-1, no WIM check.
REQ-008 SHALL have port Rett, input, 1 bit, return from trap: CWP+1, WIM-checked.
REQ-009 SHALL have port WrCWP, input, 1 bit, write strobe for CWPIn.
REQ-010 SHALL have port CWPIn, input, CWPW bits, new CWP value.
REQ-011 SHALL have port WrWIM, input, 1 bit, write strobe for WIMIn.
REQ-012 SHALL have port WIMIn, input, NWIN bits, new window-invalid mask.
REQ-013 SHALL have port CWP, output, CWPW bits, current window pointer.
REQ-014 SHALL have port WIM, output, NWIN bits, current window-invalid mask.
REQ-015 SHALL have port BlkLocal, output, NWIN bits, one-hot local/in block enable, bit CWP set.
REQ-016 SHALL have port BlkOut, output, NWIN bits, one-hot out block enable, bit (CWP-1) mod NWIN set.
REQ-017 SHALL have port Overflow, output, 1 bit, one-cycle window-overflow trap pulse.
REQ-018 SHALL have port Underflow, output, 1 bit, one-cycle window-underflow trap pulse.
REQ-019 SHALL have port WrPending, output, 1 bit, high while a delayed CWP/WIM write is in flight.

Function
REQ-020 SHALL decode BlkLocal and BlkOut combinationally from the registered CWP; they SHALL always be one-hot.
REQ-021 SHALL do all CWP arithmetic modulo NWIN: 0-1 wraps to NWIN-1, and NWIN-1+1 wraps to 0.
REQ-022 SHALL, on Save, set CWP to CWP-1 if WIM[(CWP-1) mod NWIN]==0; otherwise leave CWP unchanged and assert Overflow on the next cycle.
REQ-023 SHALL, on Restore or Rett, set CWP to CWP+1 if WIM[(CWP+1) mod NWIN]==0; otherwise leave CWP unchanged and assert Underflow on the next cycle.
REQ-024 SHALL, on TrapEntry, set CWP to CWP-1 unconditionally with no trap pulse.
REQ-025 SHALL apply the per-cycle priority: committing CWP/WIM write > TrapEntry > Rett > Save > Restore; lower-priority requests that cycle are dropped silently.
REQ-026 SHALL treat Save and Restore asserted together, with no higher-priority event, as a no-op: no CWP change, no trap.
REQ-027 SHALL register Overflow and Underflow, each high for exactly one cycle per faulting request, and never high together.
REQ-028 SHALL commit WrCWP and WrWIM independently; both committing in one cycle update both registers.
REQ-029 SHALL evaluate Save/Restore/Rett WIM checks against the WIM value before any same-cycle update.

Reset
REQ-030 SHALL, while Rst_n is low, asynchronously force CWP=0, WIM=0, Overflow=0, Underflow=0, WrPending=0 and clear the delay pipeline, so BlkLocal=1 and BlkOut=1<<(NWIN-1).
REQ-031 SHALL, on deassertion mid-operation, discard all in-flight writes and requests; normal operation resumes on the first rising edge with Rst_n high.

Configuration
REQ-032 SHALL support macro WIN_DELAYED_WRITE_EN.
REQ-033 SHALL, with WIN_DELAYED_WRITE_EN defined, pass WrCWP/CWPIn and WrWIM/WIMIn through a 3-stage pipeline and commit them on the third edge after capture; WrPending is high while any stage is valid; a newer write to the same register overwrites the older one in flight.
REQ-034 SHALL, without WIN_DELAYED_WRITE_EN, commit writes on the next edge and tie WrPending to 0.

Verification
REQ-035 SHALL cover: reset, then Save with WIM=0 -> CWP=7, BlkLocal=0x80, BlkOut=0x40, no trap.
REQ-036 SHALL cover: CWP=3, WIM=0x04, Save -> CWP stays 3, Overflow=1 for one cycle.
REQ-037 SHALL cover: CWP=7, WIM=0x01, Restore -> CWP stays 7, Underflow pulse; with WIM=0, CWP wraps to 0.
REQ-038 SHALL cover: TrapEntry and Save in the same cycle at CWP=0, WIM=0x80 -> CWP=7, no Overflow.
REQ-039 SHALL cover: WIN_DELAYED_WRITE_EN defined, WrCWP CWPIn=5 at cycle t -> CWP=5 visible after edge t+3, WrPending high for cycles t+1..t+3; Save at t+3 is dropped.
REQ-040 SHALL cover: Rst_n pulsed low mid-pipeline -> CWP=0, WIM=0, and the pending write never commits.
